// File: rtl/spikehard_dma_pkg.sv
// Shared types and constants for the spikehard 32-bit DMA responder.
// SPIKEHARD_DMA_RESP_STALL_EN uses the LFSR helpers below.
package spikehard_dma_pkg;

    localparam logic [2:0]  DMA_SIZE_WORD = 3'b010;
    localparam logic [15:0] LFSR_SEED     = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR
    } dma_state_t;

    // Fibonacci LFSR, taps 16,14,13,11
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/spikehard_dma32_responder_if.sv
// Accelerator-facing DMA read/write control and channel signals.
// The master modport is the accelerator side; the slave modport is the memory-side responder.
interface spikehard_dma32_responder_if;

    logic        dma_read_ctrl_valid;
    logic [31:0] dma_read_ctrl_data_index;
    logic [31:0] dma_read_ctrl_data_length;
    logic [2:0]  dma_read_ctrl_data_size;
    logic        dma_read_ctrl_ready;
    logic        dma_read_chnl_valid;
    logic [31:0] dma_read_chnl_data;
    logic        dma_read_chnl_ready;

    logic        dma_write_ctrl_valid;
    logic [31:0] dma_write_ctrl_data_index;
    logic [31:0] dma_write_ctrl_data_length;
    logic [2:0]  dma_write_ctrl_data_size;
    logic        dma_write_ctrl_ready;
    logic        dma_write_chnl_valid;
    logic [31:0] dma_write_chnl_data;
    logic        dma_write_chnl_ready;

    modport master (
        output dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
               dma_read_ctrl_data_size, dma_read_chnl_ready,
               dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
               dma_write_ctrl_data_size, dma_write_chnl_valid, dma_write_chnl_data,
        input  dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
               dma_write_ctrl_ready, dma_write_chnl_ready
    );

    modport slave (
        input  dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
               dma_read_ctrl_data_size, dma_read_chnl_ready,
               dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
               dma_write_ctrl_data_size, dma_write_chnl_valid, dma_write_chnl_data,
        output dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
               dma_write_ctrl_ready, dma_write_chnl_ready
    );

endinterface

// File: rtl/spikehard_skid_buf_2.sv
// Two-entry valid/ready buffer for 32-bit read data; the caller keeps pushes within capacity via count.
module spikehard_skid_buf_2 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic [1:0]  count
);

    logic [31:0] head;
    logic [31:0] tail;
    logic        pop;

    assign out_valid = (count != 2'd0);
    assign out_data  = out_valid ? head : '0;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else begin
            count <= count + 2'(in_valid) - 2'(pop);
        end
    end

    // head always holds the oldest entry; tail only fills when head is occupied after this edge
    always_ff @(posedge clk) begin
        if (pop) begin
            head <= (count == 2'd2) ? tail : in_data;
        end else if (in_valid && count == 2'd0) begin
            head <= in_data;
        end
        if (in_valid && ((count == 2'd2 && pop) || (count == 2'd1 && !pop))) begin
            tail <= in_data;
        end
    end

endmodule

// File: rtl/spikehard_dma32_responder.sv
// Memory-side DMA responder with host back-door port over a word-addressed internal RAM.
// Define SPIKEHARD_DMA_RESP_STALL_EN to gate ready/issue with an LFSR for pseudo-random stalls.
module spikehard_dma32_responder
    import spikehard_dma_pkg::*;
#(
    parameter int unsigned MEM_WORDS  = 4096,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    spikehard_dma32_responder_if.slave dma,
    input  logic                    host_we,
    input  logic [ADDR_WIDTH-1:0]   host_addr,
    input  logic [31:0]             host_wdata,
    output logic [31:0]             host_rdata,
    output logic                    busy,
    output logic                    err_size
);

    dma_state_t            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           remaining;
    logic [31:0]           mem [MEM_WORDS];
    logic [31:0]           rd_q;
    logic                  inflight;
    logic [1:0]            sb_count;
    logic                  sb_pop;
    logic [2:0]            occ_after;
    logic                  rd_issue;
    logic                  wr_beat;
    logic                  go_data;
    logic                  go_ctrl;
    logic                  unused_index_hi;

    assign unused_index_hi = ^{dma.dma_read_ctrl_data_index[31:ADDR_WIDTH],
                               dma.dma_write_ctrl_data_index[31:ADDR_WIDTH]};

`ifdef SPIKEHARD_DMA_RESP_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign go_data = lfsr[0];
    assign go_ctrl = lfsr[1];
`else
    assign go_data = 1'b1;
    assign go_ctrl = 1'b1;
`endif

    assign busy = (state != IDLE);

    assign dma.dma_read_ctrl_ready  = (state == IDLE) && go_ctrl && dma.dma_read_ctrl_valid;
    assign dma.dma_write_ctrl_ready = (state == IDLE) && go_ctrl && dma.dma_write_ctrl_valid
                                      && !dma.dma_read_ctrl_valid;
    assign dma.dma_write_chnl_ready = (state == WR) && (remaining != '0) && go_data;
    assign wr_beat                  = dma.dma_write_chnl_valid && dma.dma_write_chnl_ready;

    // Occupancy net of this cycle's pop lets one read issue per cycle while the consumer keeps up
    assign sb_pop    = dma.dma_read_chnl_valid && dma.dma_read_chnl_ready;
    assign occ_after = {1'b0, sb_count} + {2'b0, inflight} - {2'b0, sb_pop};
    assign rd_issue  = (state == RD) && (remaining != '0) && go_data && (occ_after < 3'd2);

    always_ff @(posedge clk) begin
        if (host_we) begin
            mem[host_addr] <= host_wdata;
        end
        if (wr_beat) begin
            mem[addr] <= dma.dma_write_chnl_data;
        end
        if (rd_issue) begin
            rd_q <= mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            host_rdata <= '0;
        end else begin
            host_rdata <= mem[host_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            err_size  <= 1'b0;
        end else begin
            inflight <= rd_issue;
            unique case (state)
                IDLE: begin
                    if (dma.dma_read_ctrl_ready) begin
                        addr      <= dma.dma_read_ctrl_data_index[ADDR_WIDTH-1:0];
                        remaining <= dma.dma_read_ctrl_data_length;
                        if (dma.dma_read_ctrl_data_length != '0) begin
                            state <= RD;
                        end
                        if (dma.dma_read_ctrl_data_size != DMA_SIZE_WORD) begin
                            err_size <= 1'b1;
                        end
                    end else if (dma.dma_write_ctrl_ready) begin
                        addr      <= dma.dma_write_ctrl_data_index[ADDR_WIDTH-1:0];
                        remaining <= dma.dma_write_ctrl_data_length;
                        if (dma.dma_write_ctrl_data_length != '0) begin
                            state <= WR;
                        end
                        if (dma.dma_write_ctrl_data_size != DMA_SIZE_WORD) begin
                            err_size <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (rd_issue) begin
                        addr      <= addr + ADDR_WIDTH'(1);
                        remaining <= remaining - 32'd1;
                    end
                    if (remaining == '0 && !inflight && occ_after == 3'd0) begin
                        state <= IDLE;
                    end
                end
                WR: begin
                    if (wr_beat) begin
                        addr      <= addr + ADDR_WIDTH'(1);
                        remaining <= remaining - 32'd1;
                        if (remaining == 32'd1) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    spikehard_skid_buf_2 u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inflight),
        .in_data   (rd_q),
        .out_valid (dma.dma_read_chnl_valid),
        .out_data  (dma.dma_read_chnl_data),
        .out_ready (dma.dma_read_chnl_ready),
        .count     (sb_count)
    );

endmodule

// File: doc/spikehard_dma32_responder.md
Name: spikehard_dma32_responder

Overview:
- Memory-side DMA responder for the 32-bit spikehard accelerator interface.
- Accepts read and write control requests from the accelerator and streams words out of, or into, an internal word-addressed memory.
- Used in simulation and FPGA bring-up as a stand-in for the SoC DMA engine.
- A host back-door port preloads input spike data and inspects results.

Parameters:
- MEM_WORDS, 4096, depth of internal memory in 32-bit words (power of two).
- ADDR_WIDTH, 12, log2(MEM_WORDS).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-low reset.
- dma_read_ctrl_valid  input  1  read request valid.
- dma_read_ctrl_data_index  input  32  start word index.
- dma_read_ctrl_data_length  input  32  burst length in words.
- dma_read_ctrl_data_size  input  3  beat size; 3'b010 = 32-bit.
- dma_read_ctrl_ready  output  1  read request accepted.
- dma_read_chnl_valid  output  1  read data valid.
- dma_read_chnl_data  output  32  read data.
- dma_read_chnl_ready  input  1  accelerator accepts read data.
- dma_write_ctrl_valid, _data_index, _data_length, _data_size  input  1/32/32/3  write request; same fields as read.
- dma_write_ctrl_ready  output  1  write request accepted.
- dma_write_chnl_valid  input  1  write data valid.
- dma_write_chnl_data  input  32  write data.
- dma_write_chnl_ready  output  1  responder accepts write data.
- host_we  input  1  back-door write strobe.
- host_addr  input  ADDR_WIDTH  back-door word address.
- host_wdata  input  32  back-door write data.
- host_rdata  output  32  back-door read data, registered, 1-cycle latency.
- busy  output  1  FSM not in IDLE.
- err_size  output  1  sticky; set when an accepted request has data_size != 3'b010.

Behaviour:
- Reset (rst low at a clk edge):
  - All outputs go to 0, FSM goes to IDLE, skid buffer empties, err_size clears.
  - Memory contents are not cleared.
  - Reset mid-burst abandons the burst; no further beats are produced or accepted.
- Handshakes: a transfer occurs on a cycle where valid && ready. Once valid is raised, data stays stable until accepted.
- FSM states: IDLE, RD, WR.
- IDLE:
  - Read has fixed priority over write.
  - dma_read_ctrl_ready = 1 whenever dma_read_ctrl_valid is high.
  - dma_write_ctrl_ready = dma_write_ctrl_valid && !dma_read_ctrl_valid.
  - On a handshake, latch address = index[ADDR_WIDTH-1:0] and remaining = length, then go to RD or WR.
  - Length 0: handshake completes, FSM stays in IDLE, no beats.
  - Ctrl ready is 0 in RD and WR.
- RD:
  - Synchronous RAM read, 1-cycle latency, feeding a 2-entry skid buffer that drives dma_read_chnl_valid/data.
  - A RAM read issues when remaining != 0 and the skid buffer has space counting in-flight reads.
  - Each issue increments the address (wraps modulo MEM_WORDS) and decrements remaining.
  - First beat: dma_read_chnl_valid rises 2 cycles after the ctrl handshake.
  - Sustained throughput: 1 beat/cycle while ready stays high.
  - Return to IDLE the cycle after the last beat handshake.
- WR:
  - dma_write_chnl_ready = 1 while remaining != 0.
  - Each handshake writes the word at the address, increments the address (wrap) and decrements remaining.
  - Return to IDLE the cycle after the last write. No ready bubbles.
- Back-door port:
  - host_rdata is always valid 1 cycle after host_addr is presented.
  - A host_we write in the same cycle as a DMA write to the same address: DMA wins. Host writes at other addresses proceed.
- Index bits above ADDR_WIDTH are ignored. Length is 32 bits with no upper bound; the address wraps.

Optional Feature:
- SPIKEHARD_DMA_RESP_STALL_EN defined: a 16-bit LFSR (seed 16'hACE1 at reset, taps 16,14,13,11) masks stalls:
  - dma_write_chnl_ready and RAM read issue are gated with LFSR[0], so they stall pseudo-randomly.
  - IDLE ctrl ready is gated with LFSR[1].
  - Data ordering and content are unchanged.
- Undefined: no gating, with the full-throughput timing above.

Decomposition:
- Shared package spikehard_dma_pkg:
  - DMA_SIZE_WORD = 3'b010.
  - FSM state typedef {IDLE, RD, WR}.
  - LFSR seed constant.
- One sub-module: spikehard_skid_buf_2 (2-entry valid/ready buffer, 32-bit data).

Test Plan:
- Preload mem[0..7] = 100..107 via host; read index 0, length 8, chnl_ready held 1 -> beats 100..107 on consecutive cycles, first valid 2 cycles after ctrl handshake.
- Read length 4 with chnl_ready toggling 1,0,0,1... -> no beat lost or duplicated; data held stable while stalled.
- Write index 4094, length 4, data A0..A3 -> host readback gives mem[4094]=A0, mem[4095]=A1, mem[0]=A2, mem[1]=A3.
- Read and write ctrl valid in the same cycle -> read accepted first; write accepted in the first IDLE cycle after the read completes.
- Length 0 read, then size=3'b011 write of length 1 -> no beats for the read, busy stays 0; write completes and err_size=1 until reset.
- Assert reset mid-read at beat 3 of 8 -> all outputs 0 next cycle; a subsequent read returns correct data.
